// File: rtl/mips_memory_access_controller.sv
// Memory-stage data access sequencer: drives a req/ack memory port with byte lanes, stalls the pipeline,
// returns extended load data and faults on a silent bus. Optional alignment check: MIPS_MEMORY_ACCESS_ALIGN_CHECK_EN.
module mips_memory_access_controller #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              stall,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              fault,
  output logic              misalign,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_we, r_uns, r_fault, r_misalign;
  logic [1:0]        r_size, r_lane;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_be;
  logic [31:0]       r_wdata, r_rdata;
  logic              w_req, w_misalign, w_timeout;

  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'd1:    lane_be = 4'b0001 << a;
      2'd2:    lane_be = a[1] ? 4'b1100 : 4'b0011;
      default: lane_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      2'd1:    lane_wdata = {4{wd[7:0]}};
      2'd2:    lane_wdata = {2{wd[15:0]}};
      default: lane_wdata = wd;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] raw, input logic [1:0] size,
                                              input logic [1:0] lane, input logic uns);
    logic [31:0]        w_sh;
    logic signed [7:0]  w_b;
    logic signed [15:0] w_h;
    logic signed [31:0] w_sb, w_shw;
    case (size)
      2'd1:    w_sh = raw >> {lane, 3'b000};
      2'd2:    w_sh = raw >> {lane[1], 4'b0000};
      default: w_sh = raw;
    endcase
    w_b   = w_sh[7:0];
    w_h   = w_sh[15:0];
    w_sb  = 32'(w_b);
    w_shw = 32'(w_h);
    case (size)
      2'd1:    load_extend = uns ? {24'd0, w_sh[7:0]} : w_sb;
      2'd2:    load_extend = uns ? {16'd0, w_sh[15:0]} : w_shw;
      default: load_extend = w_sh;
    endcase
  endfunction

  assign w_req = req_valid & (req_size != 2'd0);
`ifdef MIPS_MEMORY_ACCESS_ALIGN_CHECK_EN
  assign w_misalign = ((req_size == 2'd2) & req_addr[0]) |
                      ((req_size == 2'd3) & (req_addr[1:0] != 2'd0));
`else
  assign w_misalign = 1'b0;
`endif
  assign w_timeout = (TIMEOUT != 0) && (r_cnt == CNT_MAX);

  // Reset is folded into stall so every output reads 0 while it is held.
  assign stall      = ~reset & w_req & (r_state != S_DONE);
  assign resp_valid = (r_state == S_DONE);
  assign resp_rdata = r_rdata;
  assign fault      = r_fault;
  assign misalign   = r_misalign;
  assign mem_req    = (r_state == S_BUSY);
  assign mem_we     = r_we;
  assign mem_addr   = r_addr;
  assign mem_be     = r_be;
  assign mem_wdata  = r_wdata;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_we       <= 1'b0;
      r_uns      <= 1'b0;
      r_size     <= 2'd0;
      r_lane     <= 2'd0;
      r_addr     <= '0;
      r_be       <= 4'd0;
      r_wdata    <= 32'd0;
      r_rdata    <= 32'd0;
      r_fault    <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_we    <= req_write;
            r_uns   <= req_unsigned;
            r_size  <= req_size;
            r_lane  <= req_addr[1:0];
            r_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
            r_be    <= lane_be(req_size, req_addr[1:0]);
            r_wdata <= lane_wdata(req_size, req_wdata);
            r_cnt   <= '0;
            if (w_misalign) begin
              r_state    <= S_DONE;
              r_misalign <= 1'b1;
            end else begin
              r_state <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          // An ack arriving together with the last allowed cycle still completes cleanly.
          if (mem_ack) begin
            r_state <= S_DONE;
            r_rdata <= r_we ? 32'd0 : load_extend(mem_rdata, r_size, r_lane, r_uns);
          end else if (w_timeout) begin
            r_state <= S_DONE;
            r_fault <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          r_state    <= S_IDLE;
          r_rdata    <= 32'd0;
          r_fault    <= 1'b0;
          r_misalign <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mips_memory_access_controller.sv
// Self-checking bench for mips_memory_access_controller: directed scenarios plus randomized
// accesses checked against a byte-lane reference model.
module tb_mips_memory_access_controller;
  localparam int TO = 15;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        stall, resp_valid, fault, misalign;
  logic [31:0] resp_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int n_tests = 0;
  int n_fail  = 0;

  // Observations from the last access driven by run_access.
  int          o_stall, o_busy, o_resp_cyc;
  logic [3:0]  o_be;
  logic [31:0] o_addr, o_wdata, o_rdata;
  logic        o_we, o_fault, o_mis;
  time         o_t0;

  mips_memory_access_controller #(.ADDR_W(32), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .fault(fault), .misalign(misalign),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Issues one request at the next cycle; ack arrives on BUSY cycle ack_delay+1,
  // req_valid is withdrawn after BUSY cycle flush_busy (flush).
  task automatic run_access(input logic wr, input logic [1:0] sz, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input logic [31:0] rd, input int ack_delay, input int flush_busy);
    int busy;
    busy = 0;
    o_stall = 0; o_resp_cyc = -1; o_be = 4'd0; o_addr = 32'd0; o_wdata = 32'd0;
    o_rdata = 32'hxxxxxxxx; o_we = 1'b0; o_fault = 1'bx; o_mis = 1'bx;
    @(negedge clock);
    o_t0 = $time;
    req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    for (int c = 0; c < 60; c++) begin
      if (c > 0) @(negedge clock);
      mem_ack = 1'b0;
      mem_rdata = $urandom;
      #1;
      if (stall) o_stall++;
      if (resp_valid) begin
        o_resp_cyc = c; o_rdata = resp_rdata; o_fault = fault; o_mis = misalign;
        req_valid = 1'b0;
        break;
      end
      if (mem_req) begin
        busy++;
        if (busy == 1) begin
          o_be = mem_be; o_addr = mem_addr; o_wdata = mem_wdata; o_we = mem_we;
        end
        if (busy == ack_delay + 1) begin
          mem_ack = 1'b1; mem_rdata = rd;
        end
        if (busy == flush_busy) req_valid = 1'b0;
      end
    end
    o_busy = busy;
    req_valid = 1'b0;
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] rd, input int sz, input int a,
                                             input logic uns);
    int nbytes, lane;
    logic [31:0] v, mask;
    nbytes = (sz == 3) ? 4 : (sz == 2) ? 2 : 1;
    lane   = (sz == 3) ? 0 : (sz == 2) ? (a / 2) * 2 : a;
    v = rd >> (8 * lane);
    if (nbytes == 4) return v;
    mask = (32'd1 << (8 * nbytes)) - 32'd1;
    v = v & mask;
    if (!uns && v > (mask >> 1)) v = v | ~mask;
    return v;
  endfunction

  task automatic test_reset;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
    repeat (2) @(negedge clock);
    #1;
    n_tests++;
    if ({stall, resp_valid, resp_rdata, fault, misalign, mem_req, mem_we, mem_addr, mem_be, mem_wdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got stall=%b rv=%b rd=%h f=%b m=%b req=%b we=%b a=%h be=%h wd=%h want all 0",
               stall, resp_valid, resp_rdata, fault, misalign, mem_req, mem_we, mem_addr, mem_be, mem_wdata);
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_lw;
    run_access(1'b0, 2'd3, 1'b0, 32'h100, 32'd0, 32'hDEADBEEF, 0, -1);
    n_tests++; if (o_be !== 4'hF) begin n_fail++; $display("FAIL lw_be got %h want f", o_be); end
    n_tests++; if (o_addr !== 32'h100) begin n_fail++; $display("FAIL lw_addr got %h want 100", o_addr); end
    n_tests++; if (o_stall !== 2) begin n_fail++; $display("FAIL lw_stall got %0d want 2", o_stall); end
    n_tests++; if (o_resp_cyc !== 2) begin n_fail++; $display("FAIL lw_latency got %0d want 2", o_resp_cyc); end
    n_tests++; if (o_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_rdata got %h want deadbeef", o_rdata); end
  endtask

  task automatic test_lb;
    run_access(1'b0, 2'd1, 1'b0, 32'h103, 32'd0, 32'h80FF0000, 0, -1);
    n_tests++; if (o_be !== 4'h8) begin n_fail++; $display("FAIL lb_be got %h want 8", o_be); end
    n_tests++; if (o_rdata !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb_rdata got %h want ffffff80", o_rdata); end
    run_access(1'b0, 2'd1, 1'b1, 32'h103, 32'd0, 32'h80FF0000, 0, -1);
    n_tests++; if (o_rdata !== 32'h00000080) begin n_fail++; $display("FAIL lbu_rdata got %h want 00000080", o_rdata); end
  endtask

  task automatic test_sh;
    run_access(1'b1, 2'd2, 1'b0, 32'h0102, 32'h1234ABCD, 32'h55555555, 3, -1);
    n_tests++; if (o_be !== 4'hC) begin n_fail++; $display("FAIL sh_be got %h want c", o_be); end
    n_tests++; if (o_wdata !== 32'hABCDABCD) begin n_fail++; $display("FAIL sh_wdata got %h want abcdabcd", o_wdata); end
    n_tests++; if (o_we !== 1'b1) begin n_fail++; $display("FAIL sh_we got %b want 1", o_we); end
    n_tests++; if (o_resp_cyc !== 5) begin n_fail++; $display("FAIL sh_latency got %0d want 5", o_resp_cyc); end
    n_tests++; if (o_rdata !== 32'd0) begin n_fail++; $display("FAIL sh_rdata got %h want 0", o_rdata); end
  endtask

  task automatic test_timeout;
    run_access(1'b0, 2'd3, 1'b0, 32'h40, 32'd0, 32'h0, 1000, -1);
    n_tests++; if (o_busy !== TO + 1) begin n_fail++; $display("FAIL to_req_cycles got %0d want %0d", o_busy, TO + 1); end
    n_tests++; if (o_fault !== 1'b1) begin n_fail++; $display("FAIL to_fault got %b want 1", o_fault); end
    n_tests++; if (o_rdata !== 32'd0) begin n_fail++; $display("FAIL to_rdata got %h want 0", o_rdata); end
    @(negedge clock); #1;
    n_tests++;
    if ({fault, resp_valid} !== 2'b00) begin
      n_fail++; $display("FAIL to_fault_clear got fault=%b rv=%b want 0 0", fault, resp_valid);
    end
    run_access(1'b0, 2'd3, 1'b0, 32'h40, 32'd0, 32'h13572468, TO, -1);
    n_tests++; if (o_fault !== 1'b0) begin n_fail++; $display("FAIL to_ack_wins_fault got %b want 0", o_fault); end
    n_tests++; if (o_rdata !== 32'h13572468) begin n_fail++; $display("FAIL to_ack_wins_rdata got %h want 13572468", o_rdata); end
    n_tests++; if (o_resp_cyc !== TO + 2) begin n_fail++; $display("FAIL to_ack_wins_latency got %0d want %0d", o_resp_cyc, TO + 2); end
  endtask

  task automatic test_misalign;
    run_access(1'b0, 2'd3, 1'b0, 32'h102, 32'd0, 32'hCAFEF00D, 0, -1);
`ifdef MIPS_MEMORY_ACCESS_ALIGN_CHECK_EN
    n_tests++; if (o_busy !== 0) begin n_fail++; $display("FAIL mis_no_req got %0d want 0", o_busy); end
    n_tests++; if (o_mis !== 1'b1) begin n_fail++; $display("FAIL mis_flag got %b want 1", o_mis); end
    n_tests++; if (o_resp_cyc !== 1) begin n_fail++; $display("FAIL mis_latency got %0d want 1", o_resp_cyc); end
    n_tests++; if (o_rdata !== 32'd0) begin n_fail++; $display("FAIL mis_rdata got %h want 0", o_rdata); end
    @(negedge clock); #1;
    n_tests++; if (misalign !== 1'b0) begin n_fail++; $display("FAIL mis_clear got %b want 0", misalign); end
`else
    n_tests++; if (o_addr !== 32'h100) begin n_fail++; $display("FAIL mis_addr got %h want 100", o_addr); end
    n_tests++; if (o_be !== 4'hF) begin n_fail++; $display("FAIL mis_be got %h want f", o_be); end
    n_tests++; if (o_mis !== 1'b0) begin n_fail++; $display("FAIL mis_flag got %b want 0", o_mis); end
    n_tests++; if (o_rdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL mis_rdata got %h want cafef00d", o_rdata); end
`endif
  endtask

  task automatic test_flush;
    run_access(1'b0, 2'd3, 1'b0, 32'h300, 32'd0, 32'h0BADF00D, 2, 1);
    n_tests++; if (o_resp_cyc !== 4) begin n_fail++; $display("FAIL flush_latency got %0d want 4", o_resp_cyc); end
    n_tests++; if (o_stall !== 2) begin n_fail++; $display("FAIL flush_stall got %0d want 2", o_stall); end
  endtask

  task automatic test_no_request;
    @(negedge clock);
    req_valid = 1'b1; req_size = 2'd0; req_addr = 32'h500; mem_ack = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock); #1;
      n_tests++;
      if ({stall, mem_req, resp_valid} !== 3'b000) begin
        n_fail++; $display("FAIL noreq_cyc%0d got stall=%b req=%b rv=%b want 0 0 0", c, stall, mem_req, resp_valid);
      end
    end
    req_valid = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic test_back_to_back;
    time t[3];
    for (int k = 0; k < 3; k++) begin
      run_access(1'b0, 2'd3, 1'b0, 32'h600 + 32'(4 * k), 32'd0, 32'h1000 + 32'(k), 0, -1);
      t[k] = o_t0;
      n_tests++;
      if (o_rdata !== 32'h1000 + 32'(k)) begin n_fail++; $display("FAIL b2b%0d_rdata got %h want %h", k, o_rdata, 32'h1000 + 32'(k)); end
    end
    n_tests++;
    if ((t[1] - t[0] !== 30) || (t[2] - t[1] !== 30)) begin
      n_fail++; $display("FAIL b2b_rate got %0t/%0t want 30/30", t[1] - t[0], t[2] - t[1]);
    end
  endtask

  task automatic test_reset_midbusy;
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd3; req_unsigned = 1'b0;
    req_addr = 32'h200; mem_ack = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    n_tests++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rstbusy_pre got req=%b want 1", mem_req); end
    reset = 1'b1;
    #1;
    n_tests++;
    if ({stall, resp_valid, resp_rdata, fault, misalign, mem_req, mem_we, mem_addr, mem_be, mem_wdata} !== '0) begin
      n_fail++;
      $display("FAIL rstbusy_outputs got req=%b stall=%b rv=%b a=%h be=%h want all 0", mem_req, stall, resp_valid, mem_addr, mem_be);
    end
    @(negedge clock);
    req_valid = 1'b0;
    reset = 1'b0;
    @(negedge clock); #1;
    n_tests++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rstbusy_no_resp got %b want 0", resp_valid); end
    run_access(1'b0, 2'd3, 1'b0, 32'h204, 32'd0, 32'hA5A5F00F, 1, -1);
    n_tests++; if (o_rdata !== 32'hA5A5F00F) begin n_fail++; $display("FAIL rstbusy_after_rdata got %h want a5a5f00f", o_rdata); end
    n_tests++; if (o_resp_cyc !== 3) begin n_fail++; $display("FAIL rstbusy_after_latency got %0d want 3", o_resp_cyc); end
  endtask

  task automatic test_random;
    for (int i = 0; i < 40; i++) begin
      logic        wr, uns, mis, tmo;
      logic [1:0]  sz;
      logic [31:0] addr, wd, rd, e_rd, e_wd;
      logic [3:0]  e_be;
      int          a, r, dly, e_busy, e_cyc;
      wr = 1'($urandom); uns = 1'($urandom); sz = 2'($urandom_range(1, 3));
      addr = $urandom; wd = $urandom; rd = $urandom;
      a = int'(addr[1:0]);
      r = $urandom_range(0, 9);
      dly = (r == 9) ? 1000 : (r == 8) ? TO : r % 4;
`ifdef MIPS_MEMORY_ACCESS_ALIGN_CHECK_EN
      mis = (sz == 2'd2 && (a % 2) != 0) || (sz == 2'd3 && a != 0);
`else
      mis = 1'b0;
`endif
      tmo = !mis && (dly > TO);
      e_be = (sz == 2'd1) ? 4'(1 << a) : (sz == 2'd2) ? 4'(3 << ((a / 2) * 2)) : 4'hF;
      e_wd = (sz == 2'd1) ? (wd & 32'hFF) * 32'h01010101 :
             (sz == 2'd2) ? (wd & 32'hFFFF) * 32'h00010001 : wd;
      e_busy = mis ? 0 : tmo ? TO + 1 : dly + 1;
      e_cyc  = mis ? 1 : e_busy + 1;
      e_rd   = (mis || tmo || wr) ? 32'd0 : model_load(rd, int'(sz), a, uns);
      run_access(wr, sz, uns, addr, wd, rd, dly, -1);
      n_tests++; if (o_resp_cyc !== e_cyc) begin n_fail++; $display("FAIL rnd%0d_latency got %0d want %0d", i, o_resp_cyc, e_cyc); end
      n_tests++; if (o_stall !== e_cyc) begin n_fail++; $display("FAIL rnd%0d_stall got %0d want %0d", i, o_stall, e_cyc); end
      n_tests++; if (o_busy !== e_busy) begin n_fail++; $display("FAIL rnd%0d_busy got %0d want %0d", i, o_busy, e_busy); end
      n_tests++; if (o_rdata !== e_rd) begin n_fail++; $display("FAIL rnd%0d_rdata got %h want %h", i, o_rdata, e_rd); end
      n_tests++; if ({o_fault, o_mis} !== {tmo, mis}) begin n_fail++; $display("FAIL rnd%0d_flags got %b%b want %b%b", i, o_fault, o_mis, tmo, mis); end
      if (!mis) begin
        n_tests++; if (o_be !== e_be) begin n_fail++; $display("FAIL rnd%0d_be got %h want %h", i, o_be, e_be); end
        n_tests++; if (o_addr !== (addr & 32'hFFFFFFFC)) begin n_fail++; $display("FAIL rnd%0d_addr got %h want %h", i, o_addr, addr & 32'hFFFFFFFC); end
        n_tests++; if (o_wdata !== e_wd) begin n_fail++; $display("FAIL rnd%0d_wdata got %h want %h", i, o_wdata, e_wd); end
        n_tests++; if (o_we !== wr) begin n_fail++; $display("FAIL rnd%0d_we got %b want %b", i, o_we, wr); end
      end
    end
  endtask

  initial begin
    test_reset;
    test_lw;
    test_lb;
    test_sh;
    test_timeout;
    test_misalign;
    test_flush;
    test_no_request;
    test_back_to_back;
    test_reset_midbusy;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mips_memory_access_controller.md
# mips_memory_access_controller

Sequences data-memory accesses for the memory pipeline stage. Consumes the per-instruction memory control (write enable, byte-enable size, byte-extend), drives a single req/ack data-memory port with byte lanes, stalls the pipeline until the access completes, and returns aligned, extended load data. It also enforces a bus timeout so a silent memory cannot hang the core.

## Interface
- `ADDR_W`, default 32: byte address width.
- `TIMEOUT`, default 15: maximum BUSY cycles without `mem_ack` before a fault; 0 disables the timeout.

- `clock` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `req_valid` in 1: the memory-stage instruction has a memory op (size ≠ None).
- `req_write` in 1: store if 1, load if 0.
- `req_size` in 2: 0 None, 1 Byte, 2 Half, 3 Word.
- `req_unsigned` in 1: zero-extend the load if 1, sign-extend if 0.
- `req_addr` in `ADDR_W`: byte address.
- `req_wdata` in 32: store data, right-justified.
- `stall` out 1: freezes the pipeline at and before the memory stage.
- `resp_valid` out 1: one-cycle pulse when the access is finished.
- `resp_rdata` out 32: extended load data; 0 for stores and faults.
- `fault` out 1: timeout flag, valid with `resp_valid`.
- `misalign` out 1: misaligned-access flag, valid with `resp_valid`.
- `mem_req` out 1: memory request.
- `mem_we` out 1: memory write enable.
- `mem_addr` out `ADDR_W`: word-aligned address; bits [1:0] are always 0.
- `mem_be` out 4: byte-lane enables.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_ack` in 1: access complete; for reads, `mem_rdata` is valid in the same cycle.
- `mem_rdata` in 32: raw word read from memory.

## Operation
- FSM states: IDLE, BUSY, DONE.
  - IDLE, `req_valid`=1: latch write, size, unsigned, addr, wdata and lane info, then go to BUSY. Exception: a misaligned request with the check enabled goes to DONE.
  - BUSY, `mem_ack`=1: capture read data, go to DONE.
  - BUSY, counter = `TIMEOUT` (≠0) and no ack: go to DONE with the fault flag set.
  - DONE: `resp_valid`=1, then go to IDLE unconditionally.
- `stall` = `req_valid` & (state ≠ DONE), combinational.
- `mem_req` = (state == BUSY); all `mem_*` outputs are driven from latched registers.
- Lanes are little-endian.
  - Byte: `mem_be` = 1<<a[1:0]; `mem_wdata` = the low byte replicated 4 times.
  - Half: `mem_be` = 3<<(2·a[1]); `mem_wdata` = the low half replicated 2 times.
  - Word: `mem_be` = 4'hF.
- Load data: select the lane, then sign- or zero-extend to 32 bits. Stores return 0.
- Timeout counter: width ⌈log2(TIMEOUT+1)⌉, cleared on IDLE→BUSY, increments each BUSY cycle without ack.
- An ack in the same cycle the counter reaches `TIMEOUT`: the ack wins, and `fault`=0.
- `mem_ack` is ignored outside BUSY.
- `req_valid` dropping during BUSY (flush): the bus transaction still completes and `resp_valid` still pulses. The pipeline discards the response.
- `req_size`=0 with `req_valid`=1 is treated as no request.
- Reset values: state IDLE, counter 0. Every output is 0 (`stall`, `resp_valid`, `resp_rdata`, `fault`, `misalign`, `mem_req`, `mem_we`, `mem_addr`, `mem_be`, `mem_wdata`).
- Reset mid-BUSY drops `mem_req` asynchronously and produces no response.

## Timing
- Zero-wait memory (ack in the first BUSY cycle): request at cycle 0, BUSY at cycle 1, DONE at cycle 2. `stall` is high in cycles 0–1 and `resp_valid` is high in cycle 2.
- N wait cycles add N cycles to both stall and latency.
- Back-to-back requests: IDLE is re-entered after DONE, so issue rate is at most one access per 3 cycles.
- Timeout: DONE is reached `TIMEOUT`+1 cycles after entering BUSY, with `fault`=1.
- `fault`, `misalign` and `resp_rdata` are registered and held for exactly the DONE cycle, then cleared to 0.

## Configuration
- `MIPS_MEMORY_ACCESS_ALIGN_CHECK_EN`
- Defined:
  - Half with a[0]=1, or Word with a[1:0]≠0, is misaligned.
  - A misaligned access goes IDLE→DONE without `mem_req`.
  - In DONE: `misalign`=1, `resp_rdata`=0, `stall` for 1 cycle.
- Undefined:
  - Address bits below the access size are ignored (forced aligned).
  - `misalign` is tied to 0.

## Test plan
- LW at 0x100, zero-wait, `mem_rdata`=0xDEADBEEF -> `mem_be`=F, `mem_addr`=0x100; `stall` high for 2 cycles; `resp_rdata`=0xDEADBEEF in cycle 2.
- LB at 0x103 with `mem_rdata`=0x80FF0000 -> `mem_be`=8, `resp_rdata`=0xFFFFFF80. LBU at the same address -> 0x00000080.
- SH at 0x0102, `req_wdata`=0x1234ABCD, 3 wait cycles -> `mem_be`=C, `mem_wdata`=0xABCDABCD, `mem_we`=1; `resp_valid` at cycle 5; `resp_rdata`=0.
- LW with no ack and `TIMEOUT`=15 -> `mem_req` high for 16 cycles, then `resp_valid`=1 and `fault`=1. Repeat with the ack on the 16th cycle -> `fault`=0.
- LW at 0x102 -> with the macro: no `mem_req`, `misalign`=1 after 1 cycle; without the macro: `mem_addr`=0x100, `mem_be`=F.
- Assert `reset` in the second BUSY cycle -> `mem_req` drops immediately and all outputs go to 0. After release, a new LW completes normally.
